// File: rtl/arbitro_ram_resultado_if.sv
`default_nettype none
// ============================================================================
// Module      : arbitro_ram_resultado_if
// Description : CPU request/grant bundle plus result-DRAM port A write bus.
// Revision    : 1.0 - initial release
// ============================================================================
interface arbitro_ram_resultado_if #(
    parameter int ADDR_W = 18,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_wen;
    logic [31:0]       cpu_address;
    logic [DATA_W-1:0] cpu_data;
    logic              cpu_gnt;
    logic [ADDR_W-1:0] ram_address;
    logic [DATA_W-1:0] ram_data;
    logic              ram_wen;

    // master: the CPU side plus whoever observes the RAM port
    modport master (
        output cpu_req, cpu_wen, cpu_address, cpu_data,
        input  cpu_gnt, ram_address, ram_data, ram_wen
    );

    // slave: the arbiter that owns the RAM port
    modport slave (
        input  cpu_req, cpu_wen, cpu_address, cpu_data,
        output cpu_gnt, ram_address, ram_data, ram_wen
    );
endinterface
`default_nettype wire

// File: rtl/arbitro_ram_resultado.sv
`default_nettype none
// ============================================================================
// Module      : arbitro_ram_resultado
// Description : Phase-driven owner of result-DRAM port A: quadrant mirror
//               writes while configuring, exclusive CPU writes while running.
// Revision    : 1.0 - initial release
// ============================================================================
module arbitro_ram_resultado #(
    parameter int ADDR_W   = 18,
    parameter int DATA_W   = 32,
    parameter int CFG_ADDR = 0
) (
    input  wire logic              clock,
    input  wire logic              reset,
    input  wire logic              start,
    input  wire logic [DATA_W-1:0] quadrant,
    arbitro_ram_resultado_if.slave bus,
    output logic                   running,
    output logic                   addr_err,
    output logic [15:0]            wr_count
);

    localparam logic [ADDR_W-1:0] c_cfg_addr = ADDR_W'(CFG_ADDR);
    localparam logic [15:0]       c_cnt_max  = 16'hFFFF;

    localparam logic [1:0] S_CFG  = 2'd0;
    localparam logic [1:0] S_SYNC = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [DATA_W-1:0] r_last_q;
    logic              r_q_valid;
    logic [ADDR_W-1:0] r_ram_address;
    logic [DATA_W-1:0] r_ram_data;
    logic              r_ram_wen;
    logic              r_running;
    logic              r_addr_err;
    logic [15:0]       r_wr_count;

    logic              w_issue;
    logic [ADDR_W-1:0] w_wr_addr;
    logic [DATA_W-1:0] w_wr_data;
    logic              w_load_q;
    logic              w_clr_q;
    logic              w_clr_cnt;
    logic              w_inc_cnt;
    logic              w_set_err;
    logic [ADDR_W-1:0] w_cpu_addr_trunc;
    logic              w_cpu_addr_high;

    assign w_cpu_addr_trunc = bus.cpu_address[ADDR_W-1:0];
    assign w_cpu_addr_high  = (bus.cpu_address >> ADDR_W) != 32'd0;

    always_comb begin
        w_next_state = r_state;
        w_issue      = 1'b0;
        w_wr_addr    = c_cfg_addr;
        w_wr_data    = quadrant;
        w_load_q     = 1'b0;
        w_clr_q      = 1'b0;
        w_clr_cnt    = 1'b0;
        w_inc_cnt    = 1'b0;
        w_set_err    = 1'b0;
        case (r_state)
            S_CFG: begin
                if (start) begin
                    w_next_state = S_SYNC;
                end else if (!r_q_valid || (quadrant != r_last_q)) begin
                    w_issue  = 1'b1;
                    w_load_q = 1'b1;
                end
            end
            S_SYNC: begin
                // The mandatory mirror write lands even if start already fell.
                w_issue      = 1'b1;
                w_load_q     = 1'b1;
                w_clr_cnt    = 1'b1;
                w_next_state = start ? S_RUN : S_CFG;
            end
            S_RUN: begin
                if (bus.cpu_req && bus.cpu_wen) begin
                    w_issue   = 1'b1;
                    w_wr_addr = w_cpu_addr_trunc;
                    w_wr_data = bus.cpu_data;
                    w_inc_cnt = 1'b1;
                    w_set_err = w_cpu_addr_high;
                    // CPU overwrote the mirror word; force a rewrite on return
                    w_clr_q   = (w_cpu_addr_trunc == c_cfg_addr);
                end
                if (!start) begin
                    w_next_state = S_CFG;
                end
            end
            default: begin
                w_next_state = S_CFG;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state       <= S_CFG;
            r_last_q      <= '0;
            r_q_valid     <= 1'b0;
            r_ram_address <= '0;
            r_ram_data    <= '0;
            r_ram_wen     <= 1'b0;
            r_running     <= 1'b0;
            r_addr_err    <= 1'b0;
            r_wr_count    <= 16'd0;
        end else begin
            r_state   <= w_next_state;
            r_ram_wen <= w_issue;
            r_running <= (w_next_state == S_RUN);
            if (w_issue) begin
                r_ram_address <= w_wr_addr;
                r_ram_data    <= w_wr_data;
            end
            if (w_load_q) begin
                r_last_q  <= quadrant;
                r_q_valid <= 1'b1;
            end else if (w_clr_q) begin
                r_q_valid <= 1'b0;
            end
            if (w_set_err) begin
                r_addr_err <= 1'b1;
            end
            if (w_clr_cnt) begin
                r_wr_count <= 16'd0;
            end else if (w_inc_cnt && (r_wr_count != c_cnt_max)) begin
                r_wr_count <= r_wr_count + 16'd1;
            end
        end
    end

    assign bus.cpu_gnt     = (r_state == S_RUN);
    assign bus.ram_address = r_ram_address;
    assign bus.ram_data    = r_ram_data;
    assign bus.ram_wen     = r_ram_wen;
    assign running         = r_running;
    assign addr_err        = r_addr_err;
    assign wr_count        = r_wr_count;

endmodule
`default_nettype wire

// File: tb/tb_arbitro_ram_resultado.sv
`default_nettype none
// ============================================================================
// Module      : tb_arbitro_ram_resultado
// Description : Directed bench for arbitro_ram_resultado with a phase-level
//               reference model compared every cycle plus literal pins.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_arbitro_ram_resultado;

    localparam int ADDR_W = 18;
    localparam int DATA_W = 32;

    logic              clock = 1'b0;
    logic              reset = 1'b1;
    logic              start = 1'b0;
    logic [DATA_W-1:0] quadrant = '0;
    logic              running;
    logic              addr_err;
    logic [15:0]       wr_count;

    arbitro_ram_resultado_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    arbitro_ram_resultado #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .CFG_ADDR(0)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .quadrant (quadrant),
        .bus      (bus),
        .running  (running),
        .addr_err (addr_err),
        .wr_count (wr_count)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;
    bit cmp_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: who owns the RAM port this cycle, and what it writes.
    localparam int P_CFG  = 0;
    localparam int P_SYNC = 1;
    localparam int P_RUN  = 2;

    int          m_phase = P_CFG;
    logic        m_wen   = 1'b0;
    logic [31:0] m_addr  = '0;
    logic [31:0] m_data  = '0;
    logic [31:0] m_lq    = '0;
    logic        m_qv    = 1'b0;
    logic        m_err   = 1'b0;
    int          m_cnt   = 0;

    always @(posedge clock) begin
        if (reset) begin
            m_phase = P_CFG; m_wen = 0; m_addr = 0; m_data = 0;
            m_lq = 0; m_qv = 0; m_err = 0; m_cnt = 0;
        end else begin
            m_wen = 0;
            if (m_phase == P_CFG) begin
                if (start) m_phase = P_SYNC;
                else if (!m_qv || quadrant != m_lq) begin
                    m_wen = 1; m_addr = 0; m_data = quadrant; m_lq = quadrant; m_qv = 1;
                end
            end else if (m_phase == P_SYNC) begin
                m_wen = 1; m_addr = 0; m_data = quadrant; m_lq = quadrant; m_qv = 1;
                m_cnt = 0;
                m_phase = start ? P_RUN : P_CFG;
            end else begin
                if (bus.cpu_req && bus.cpu_wen) begin
                    m_wen  = 1;
                    m_addr = bus.cpu_address % (32'd1 << ADDR_W);
                    m_data = bus.cpu_data;
                    if (bus.cpu_address >= (32'd1 << ADDR_W)) m_err = 1;
                    if (m_addr == 0) m_qv = 0;
                    if (m_cnt < 65535) m_cnt = m_cnt + 1;
                end
                if (!start) m_phase = P_CFG;
            end
        end
    end

    always @(negedge clock) begin
        if (cmp_en) begin
            chk("cyc_ram_wen",  {31'd0, bus.ram_wen}, {31'd0, m_wen});
            chk("cyc_ram_addr", 32'(bus.ram_address), m_addr);
            chk("cyc_ram_data", bus.ram_data, m_data);
            chk("cyc_cpu_gnt",  {31'd0, bus.cpu_gnt}, {31'd0, m_phase == P_RUN});
            chk("cyc_running",  {31'd0, running}, {31'd0, m_phase == P_RUN});
            chk("cyc_addr_err", {31'd0, addr_err}, {31'd0, m_err});
            chk("cyc_wr_count", {16'd0, wr_count}, 32'(m_cnt));
        end
    end

    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic cpu(input logic req, input logic wen, input logic [31:0] a, input logic [31:0] d);
        bus.cpu_req = req; bus.cpu_wen = wen; bus.cpu_address = a; bus.cpu_data = d;
    endtask

    initial begin
        cpu(0, 0, 0, 0);
        quadrant = 32'd2;
        tick();
        cmp_en = 1'b1;
        tick();
        chk("rst_wen", {31'd0, bus.ram_wen}, 0);
        chk("rst_addr", 32'(bus.ram_address), 0);
        chk("rst_data", bus.ram_data, 0);
        chk("rst_gnt", {31'd0, bus.cpu_gnt}, 0);
        chk("rst_running", {31'd0, running}, 0);
        chk("rst_err", {31'd0, addr_err}, 0);
        chk("rst_cnt", {16'd0, wr_count}, 0);

        // first CFG write right after reset release
        reset = 1'b0;
        tick();
        chk("cfg0_wen", {31'd0, bus.ram_wen}, 1);
        chk("cfg0_addr", 32'(bus.ram_address), 0);
        chk("cfg0_data", bus.ram_data, 2);
        tick();
        chk("cfg0_idle1", {31'd0, bus.ram_wen}, 0);
        tick();
        chk("cfg0_idle2", {31'd0, bus.ram_wen}, 0);

        // quadrant 3,3,1
        quadrant = 32'd3; tick();
        chk("q3_wen", {31'd0, bus.ram_wen}, 1);
        chk("q3_data", bus.ram_data, 3);
        tick();
        chk("q3_hold", {31'd0, bus.ram_wen}, 0);
        quadrant = 32'd1; tick();
        chk("q1_wen", {31'd0, bus.ram_wen}, 1);
        chk("q1_data", bus.ram_data, 1);
        tick();
        chk("q1_idle", {31'd0, bus.ram_wen}, 0);

        // start rise: SYNC cycle, then run
        start = 1'b1; tick();
        chk("sync_gnt", {31'd0, bus.cpu_gnt}, 0);
        chk("sync_wen", {31'd0, bus.ram_wen}, 0);
        tick();
        chk("syncw_wen", {31'd0, bus.ram_wen}, 1);
        chk("syncw_data", bus.ram_data, 1);
        chk("syncw_addr", 32'(bus.ram_address), 0);
        chk("run_gnt", {31'd0, bus.cpu_gnt}, 1);
        chk("run_running", {31'd0, running}, 1);
        chk("run_cnt0", {16'd0, wr_count}, 0);

        cpu(1, 1, 32'h5, 32'hA); tick();
        chk("w5_addr", 32'(bus.ram_address), 5);
        chk("w5_data", bus.ram_data, 32'hA);
        cpu(1, 1, 32'h6, 32'hB); tick();
        chk("w6_addr", 32'(bus.ram_address), 6);
        cpu(1, 1, 32'h40005, 32'hC); tick();
        chk("wtr_addr", 32'(bus.ram_address), 5);
        chk("wtr_err", {31'd0, addr_err}, 1);
        cpu(1, 0, 32'h7, 32'hD); tick();
        chk("rd_wen", {31'd0, bus.ram_wen}, 0);
        chk("rd_cnt", {16'd0, wr_count}, 3);

        // overwrite the mirror word, then leave run
        cpu(1, 1, 32'h0, 32'hDEAD); tick();
        chk("dead_data", bus.ram_data, 32'hDEAD);
        chk("dead_cnt", {16'd0, wr_count}, 4);
        cpu(0, 0, 0, 0);
        start = 1'b0; tick();
        chk("exit_gnt", {31'd0, bus.cpu_gnt}, 0);
        chk("exit_wen", {31'd0, bus.ram_wen}, 0);
        tick();
        chk("rewr_wen", {31'd0, bus.ram_wen}, 1);
        chk("rewr_addr", 32'(bus.ram_address), 0);
        chk("rewr_data", bus.ram_data, 1);
        tick();
        chk("rewr_idle", {31'd0, bus.ram_wen}, 0);

        // one-cycle start pulse
        start = 1'b1; tick();
        chk("pulse_sync_wen", {31'd0, bus.ram_wen}, 0);
        start = 1'b0; tick();
        chk("pulse_wen", {31'd0, bus.ram_wen}, 1);
        chk("pulse_data", bus.ram_data, 1);
        chk("pulse_gnt", {31'd0, bus.cpu_gnt}, 0);
        chk("pulse_cnt", {16'd0, wr_count}, 0);
        tick();
        chk("pulse_gnt2", {31'd0, bus.cpu_gnt}, 0);
        chk("pulse_idle", {31'd0, bus.ram_wen}, 0);

        // reset in the middle of a write pulse
        quadrant = 32'd7; tick();
        chk("q7_wen", {31'd0, bus.ram_wen}, 1);
        chk("q7_data", bus.ram_data, 7);
        reset = 1'b1; quadrant = 32'd9; tick();
        chk("mid_rst_wen", {31'd0, bus.ram_wen}, 0);
        chk("mid_rst_data", bus.ram_data, 0);
        chk("mid_rst_err", {31'd0, addr_err}, 0);
        chk("mid_rst_cnt", {16'd0, wr_count}, 0);
        reset = 1'b0; tick();
        chk("q9_wen", {31'd0, bus.ram_wen}, 1);
        chk("q9_data", bus.ram_data, 9);
        tick();
        tick();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
